// File: rtl/pipe_rate_pkg.sv
// Shared definitions for the PIPE pclk rate controller.
//   rate_state_e : controller FSM states
//   rate_width() : bits needed to encode a rate code (never less than 1)
//   RATE_125/RATE_250/RATE_500 : rate codes as seen on the PIPE rate request
package pipe_rate_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StQualify,
        StGap,
        StSettle,
        StLockWait
    } rate_state_e;

    localparam logic [1:0] RATE_125 = 2'd0;
    localparam logic [1:0] RATE_250 = 2'd1;
    localparam logic [1:0] RATE_500 = 2'd2;

    function automatic int unsigned rate_width(input int unsigned rates);
        return (rates > 2) ? $clog2(rates) : 1;
    endfunction

endpackage

// File: rtl/pipe_lane_sync.sv
// Multi-flop synchroniser for an asynchronous bus into the control clock domain.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, loads RESET_VAL into every stage
//   d_i   : asynchronous input
//   q_o   : synchronised output, STAGES cycles behind d_i
// Each bit is treated independently; a multi-bit code may be seen torn for a
// cycle, which the consumer tolerates by requiring agreement over time.
module pipe_lane_sync #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    (* ASYNC_REG = "TRUE", SHIFT_EXTRACT = "NO" *) logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pipe_pclk_rate_ctrl.sv
// PIPE pclk rate controller: drives the one-hot select of the BUFGCTRL tree that
// forms pipe_pclk_in. Runs on the free-running sys_clk, never on the switched pclk.
//   sys_clk        : free-running control clock
//   sys_reset      : synchronous active-high reset
//   lane_rate_req  : per-lane requested rate code (async), lane i at [i*RW +: RW]
//   active_lanes   : lane participation mask; inactive lanes are ignored
//   mmcm_locked    : MMCM lock (async)
//   lock_lost_clr  : clears the sticky lock_lost flag
//   rate_sel       : one-hot BUFGCTRL select, all-zero only during the gap
//   cur_rate       : currently selected rate code
//   busy           : switching or recovering from lock loss
//   rate_done      : one-cycle pulse when a requested switch completes
//   lock_lost      : sticky lock-drop flag
//   bad_code       : sticky flag, an active lane requested an unsupported code
module pipe_pclk_rate_ctrl
    import pipe_rate_pkg::*;
#(
    parameter int unsigned LANES         = 8,
    parameter int unsigned RATES         = 2,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned QUAL_CYCLES   = 4,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 8,
    localparam int unsigned RW           = rate_width(RATES)
) (
    input  logic                sys_clk,
    input  logic                sys_reset,
    input  logic [LANES*RW-1:0] lane_rate_req,
    input  logic [LANES-1:0]    active_lanes,
    input  logic                mmcm_locked,
    input  logic                lock_lost_clr,
    output logic [RATES-1:0]    rate_sel,
    output logic [RW-1:0]       cur_rate,
    output logic                busy,
    output logic                rate_done,
    output logic                lock_lost,
    output logic                bad_code
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0]    QUAL_LAST  = CW'(QUAL_CYCLES - 1);
    localparam logic [CW-1:0]    GAP_LAST   = CW'(GAP_CYCLES);
    localparam logic [CW-1:0]    SETL_LAST  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0]    LOCK_LAST  = CW'(SETTLE_CYCLES - 1);
    // One bit wider than a code so the range check never degenerates when
    // RATES is a power of two.
    localparam logic [RW:0]      RATE_LIM   = (RW+1)'(RATES);
    localparam logic [RATES-1:0] SEL_ONE    = RATES'(1);
    localparam logic [RW-1:0]    RATE_SAFE  = RW'(RATE_125);

    // ---------------------------------------------------------------------
    // Synchronisers
    // ---------------------------------------------------------------------
    logic [RW-1:0] req_sync [LANES];
    logic          lock_sync;

    for (genvar g = 0; g < LANES; g++) begin : g_lane_sync
        pipe_lane_sync #(
            .WIDTH     (RW),
            .STAGES    (SYNC_STAGES),
            .RESET_VAL ('0)
        ) u_lane_sync (
            .clk_i (sys_clk),
            .rst_i (sys_reset),
            .d_i   (lane_rate_req[g*RW +: RW]),
            .q_o   (req_sync[g])
        );
    end

    // Resets to "locked" so leaving reset does not itself look like a lock drop.
    pipe_lane_sync #(
        .WIDTH     (1),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_lock_sync (
        .clk_i (sys_clk),
        .rst_i (sys_reset),
        .d_i   (mmcm_locked),
        .q_o   (lock_sync)
    );

    // ---------------------------------------------------------------------
    // Candidate agreement across active lanes
    // ---------------------------------------------------------------------
    logic [RW-1:0] cand;
    logic          cand_valid;
    logic          any_bad;
    logic          seen;
    logic          disagree;

    always_comb begin
        cand     = '0;
        any_bad  = 1'b0;
        seen     = 1'b0;
        disagree = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (active_lanes[i]) begin
                if ({1'b0, req_sync[i]} >= RATE_LIM) begin
                    any_bad = 1'b1;
                end
                if (!seen) begin
                    cand = req_sync[i];
                    seen = 1'b1;
                end else if (req_sync[i] != cand) begin
                    disagree = 1'b1;
                end
            end
        end
        cand_valid = seen & ~disagree & ~any_bad;
    end

    // ---------------------------------------------------------------------
    // FSM and counters
    // ---------------------------------------------------------------------
    rate_state_e    state_q, state_d;
    logic [CW-1:0]  qcnt_q, qcnt_d;
    logic [CW-1:0]  gcnt_q, gcnt_d;
    logic [CW-1:0]  scnt_q, scnt_d;
    logic [CW-1:0]  lcnt_q, lcnt_d;
    logic [RW-1:0]  tgt_q, tgt_d;
    logic [RATES-1:0] rate_sel_q, rate_sel_d;
    logic [RW-1:0]  cur_rate_q, cur_rate_d;
    logic           busy_q, busy_d;
    logic           rate_done_q, rate_done_d;
    logic           lock_lost_q, lock_lost_d;
    logic           bad_code_q, bad_code_d;

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        gcnt_d      = gcnt_q;
        scnt_d      = scnt_q;
        lcnt_d      = lcnt_q;
        tgt_d       = tgt_q;
        rate_sel_d  = rate_sel_q;
        cur_rate_d  = cur_rate_q;
        rate_done_d = 1'b0;
        bad_code_d  = bad_code_q | any_bad;
        // A coincident drop wins over the clear.
        lock_lost_d = (lock_lost_q & ~lock_lost_clr) | ~lock_sync;

        unique case (state_q)
            StIdle: begin
                if (cand_valid && (cand != cur_rate_q)) begin
                    tgt_d = cand;
                    if (QUAL_CYCLES == 1) begin
                        state_d    = StGap;
                        rate_sel_d = '0;
                        gcnt_d     = CW'(1);
                        qcnt_d     = '0;
                    end else begin
                        state_d = StQualify;
                        qcnt_d  = CW'(1);
                    end
                end
            end
            StQualify: begin
                if (cand_valid && (cand == tgt_q)) begin
                    if (qcnt_q == QUAL_LAST) begin
                        state_d    = StGap;
                        rate_sel_d = '0;
                        gcnt_d     = CW'(1);
                        qcnt_d     = '0;
                    end else begin
                        qcnt_d = qcnt_q + CW'(1);
                    end
                end else begin
                    state_d = StIdle;
                    qcnt_d  = '0;
                end
            end
            StGap: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d    = StSettle;
                    rate_sel_d = SEL_ONE << tgt_q;
                    cur_rate_d = tgt_q;
                    gcnt_d     = '0;
                    scnt_d     = CW'(1);
                end else begin
                    gcnt_d = gcnt_q + CW'(1);
                end
            end
            StSettle: begin
                if (scnt_q == SETL_LAST) begin
                    state_d     = StIdle;
                    rate_done_d = 1'b1;
                    scnt_d      = '0;
                end else begin
                    scnt_d = scnt_q + CW'(1);
                end
            end
            StLockWait: begin
                // Only reached here with lock_sync high; a low cycle is handled
                // by the override below and restarts the count.
                if (lcnt_q == LOCK_LAST) begin
                    state_d = StIdle;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Lock loss overrides everything: park on the lowest rate and abort.
        if (!lock_sync) begin
            state_d     = StLockWait;
            rate_sel_d  = SEL_ONE << RATE_SAFE;
            cur_rate_d  = RATE_SAFE;
            qcnt_d      = '0;
            gcnt_d      = '0;
            scnt_d      = '0;
            lcnt_d      = '0;
            rate_done_d = 1'b0;
        end

        busy_d = (state_d != StIdle) && (state_d != StQualify);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q     <= StIdle;
            qcnt_q      <= '0;
            gcnt_q      <= '0;
            scnt_q      <= '0;
            lcnt_q      <= '0;
            tgt_q       <= '0;
            rate_sel_q  <= SEL_ONE;
            cur_rate_q  <= '0;
            busy_q      <= 1'b0;
            rate_done_q <= 1'b0;
            lock_lost_q <= 1'b0;
            bad_code_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            gcnt_q      <= gcnt_d;
            scnt_q      <= scnt_d;
            lcnt_q      <= lcnt_d;
            tgt_q       <= tgt_d;
            rate_sel_q  <= rate_sel_d;
            cur_rate_q  <= cur_rate_d;
            busy_q      <= busy_d;
            rate_done_q <= rate_done_d;
            lock_lost_q <= lock_lost_d;
            bad_code_q  <= bad_code_d;
        end
    end

    assign rate_sel  = rate_sel_q;
    assign cur_rate  = cur_rate_q;
    assign busy      = busy_q;
    assign rate_done = rate_done_q;
    assign lock_lost = lock_lost_q;
    assign bad_code  = bad_code_q;

endmodule
